// File: rtl/window_gen3x3.sv
// 3x3 sliding-window generator: assembles windows from a pixel and two line-buffer taps,
// tracking the sample position so only windows fully inside the frame are emitted.
module window_gen3x3 #(
    parameter int WIDTH = 8,
    parameter int IMG_W = 1024,
    parameter int IMG_H = 1024
) (
    input  logic                       i_clk,
    input  logic                       i_resetn,
    input  logic                       i_valid,
    input  logic                       i_sof,
    input  logic [WIDTH-1:0]           i_px,
    input  logic [WIDTH-1:0]           i_px_d1,
    input  logic [WIDTH-1:0]           i_px_d2,
    output logic                       o_valid,
    output logic [9*WIDTH-1:0]         o_win,
    output logic                       o_last,
    output logic [$clog2(IMG_W)-1:0]   o_x,
    output logic [$clog2(IMG_H)-1:0]   o_y
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam logic [XW-1:0] COL_MAX = XW'(IMG_W - 1);
    localparam logic [YW-1:0] ROW_MAX = YW'(IMG_H - 1);

    // col/row hold the position the next accepted sample will take
    logic [XW-1:0] col;
    logic [YW-1:0] row;
    // column storage; element 0 is the oldest row (d2), element 2 the current row
    logic [2:0][WIDTH-1:0] win_col [3];

    logic [XW-1:0]         cur_col, nxt_col;
    logic [YW-1:0]         cur_row, nxt_row;
    logic                  col_end, row_end;
    logic                  win_done;
    logic [2:0][WIDTH-1:0] new_col;
    logic [9*WIDTH-1:0]    win_d;

    always_comb begin
        cur_col  = i_sof ? '0 : col;
        cur_row  = i_sof ? '0 : row;
        col_end  = (cur_col == COL_MAX);
        row_end  = (cur_row == ROW_MAX);
        nxt_col  = col_end ? '0 : cur_col + XW'(1);
        nxt_row  = cur_row;
        if (col_end) begin
            nxt_row = row_end ? '0 : cur_row + YW'(1);
        end
        win_done = i_valid && (cur_row >= YW'(2)) && (cur_col >= XW'(2));
        new_col  = {i_px, i_px_d1, i_px_d2};
        win_d    = '0;
        for (int i = 0; i < 3; i++) begin
            win_d[WIDTH*(3*i+0) +: WIDTH] = win_col[1][i];
            win_d[WIDTH*(3*i+1) +: WIDTH] = win_col[2][i];
            win_d[WIDTH*(3*i+2) +: WIDTH] = new_col[i];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            col        <= '0;
            row        <= '0;
            win_col[0] <= '0;
            win_col[1] <= '0;
            win_col[2] <= '0;
            o_valid    <= 1'b0;
            o_last     <= 1'b0;
            o_win      <= '0;
            o_x        <= '0;
            o_y        <= '0;
        end else begin
            o_valid <= win_done;
            o_last  <= win_done && row_end && col_end;
            if (i_valid) begin
                col        <= nxt_col;
                row        <= nxt_row;
                win_col[0] <= win_col[1];
                win_col[1] <= win_col[2];
                win_col[2] <= new_col;
            end
            if (win_done) begin
                o_win <= win_d;
                o_x   <= cur_col - XW'(1);
                o_y   <= cur_row - YW'(1);
            end
        end
    end

endmodule

// File: tb/tb_window_gen3x3.sv
// Directed bench for window_gen3x3 on a 5x4 frame with pixel(r,c) = 16*r + c.
module tb_window_gen3x3;

    localparam int W  = 8;
    localparam int IW = 5;
    localparam int IH = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic          valid;
    logic          sof;
    logic [W-1:0]  px, d1, d2;
    logic          ov;
    logic [9*W-1:0] win;
    logic          ol;
    logic [2:0]    ox;
    logic [1:0]    oy;

    window_gen3x3 #(.WIDTH(W), .IMG_W(IW), .IMG_H(IH)) dut (
        .i_clk    (clk),
        .i_resetn (rstn),
        .i_valid  (valid),
        .i_sof    (sof),
        .i_px     (px),
        .i_px_d1  (d1),
        .i_px_d2  (d2),
        .o_valid  (ov),
        .o_win    (win),
        .o_last   (ol),
        .o_x      (ox),
        .o_y      (oy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int pulses;
    int last_q[$];
    logic [9*W-1:0] first_win, last_win;
    logic [2:0] first_x, last_x, prev_x;
    logic [1:0] first_y, last_y, prev_y;
    logic [9*W-1:0] prev_win;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] pix(input int r, input int c);
        return W'(16 * r + c);
    endfunction

    task automatic clear_stats();
        pulses = 0;
        last_q.delete();
    endtask

    // One clock: drive a sample (or an idle cycle) and check the output after the edge.
    task automatic step(input bit v, input bit s, input int r, input int c);
        @(negedge clk);
        prev_win = win;
        prev_x   = ox;
        prev_y   = oy;
        valid    = v;
        sof      = s;
        if (v) begin
            px = pix(r, c);
            d1 = pix(r - 1, c);
            d2 = pix(r - 2, c);
        end else begin
            px = W'($urandom);
            d1 = W'($urandom);
            d2 = W'($urandom);
        end
        @(posedge clk);
        #1;
        if (v && r >= 2 && c >= 2) begin
            check("win_valid", 32'(ov), 32'd1);
            check("win_x", 32'(ox), 32'(c - 1));
            check("win_y", 32'(oy), 32'(r - 1));
            check("win_last", 32'(ol), 32'(r == IH - 1 && c == IW - 1));
            for (int k = 0; k < 9; k++) begin
                check($sformatf("win_e%0d", k), 32'(win[W*k +: W]),
                      32'(pix(r - 2 + k / 3, c - 2 + k % 3)));
            end
        end else begin
            check("idle_valid", 32'(ov), 32'd0);
            check("idle_last", 32'(ol), 32'd0);
            check("hold_x", 32'(ox), 32'(prev_x));
            check("hold_y", 32'(oy), 32'(prev_y));
            check("hold_win", 32'(win == prev_win), 32'd1);
        end
        if (ov) begin
            pulses++;
            if (pulses == 1) begin
                first_win = win;
                first_x   = ox;
                first_y   = oy;
            end
            if (ol) begin
                last_q.push_back(pulses);
                last_win = win;
                last_x   = ox;
                last_y   = oy;
            end
        end
    endtask

    // Samples n0..n1-1 in raster order; optional i_sof on the first and random idle gaps.
    task automatic run(input int n0, input int n1, input bit sof_first, input int max_gap);
        for (int n = n0; n < n1; n++) begin
            step(1'b1, sof_first && (n == n0), n / IW, n % IW);
            if (max_gap > 0) begin
                repeat ($urandom_range(0, max_gap)) step(1'b0, 1'($urandom), 0, 0);
            end
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, 32'(ov), 32'd0);
        check({tag, "_last"}, 32'(ol), 32'd0);
        check({tag, "_x"}, 32'(ox), 32'd0);
        check({tag, "_y"}, 32'(oy), 32'd0);
        check({tag, "_win"}, 32'(win == '0), 32'd1);
    endtask

    initial begin
        rstn  = 1'b0;
        valid = 1'b1;
        sof   = 1'b0;
        px    = 8'hAA;
        d1    = 8'hBB;
        d2    = 8'hCC;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rstn  = 1'b1;
        valid = 1'b0;

        // Continuous frame
        clear_stats();
        run(0, IW * IH, 1'b1, 0);
        check("s1_pulses", 32'(pulses), 32'd6);
        check("s1_nlast", 32'(last_q.size()), 32'd1);
        if (last_q.size() > 0) check("s1_last_idx", 32'(last_q[0]), 32'd6);
        check("s1_first_x", 32'(first_x), 32'd1);
        check("s1_first_y", 32'(first_y), 32'd1);
        check("s1_first_e0", 32'(first_win[7:0]), 32'h00);
        check("s1_first_e4", 32'(first_win[39:32]), 32'h11);
        check("s1_first_e8", 32'(first_win[71:64]), 32'h22);
        check("s1_last_x", 32'(last_x), 32'd3);
        check("s1_last_y", 32'(last_y), 32'd2);
        check("s1_last_e8", 32'(last_win[71:64]), 32'h34);

        // Same frame with random idle gaps (i_sof toggles while i_valid=0)
        clear_stats();
        run(0, IW * IH, 1'b1, 3);
        check("s2_pulses", 32'(pulses), 32'd6);
        check("s2_nlast", 32'(last_q.size()), 32'd1);

        // Two back-to-back frames, i_sof only on the first
        clear_stats();
        run(0, IW * IH, 1'b1, 0);
        run(0, IW * IH, 1'b0, 0);
        check("s3_pulses", 32'(pulses), 32'd12);
        check("s3_nlast", 32'(last_q.size()), 32'd2);
        if (last_q.size() == 2) begin
            check("s3_last0", 32'(last_q[0]), 32'd6);
            check("s3_last1", 32'(last_q[1]), 32'd12);
        end

        // i_sof reasserted where (2,3) would have been
        clear_stats();
        run(0, 2 * IW + 3, 1'b1, 0);
        check("s4_partial_pulses", 32'(pulses), 32'd1);
        check("s4_partial_nlast", 32'(last_q.size()), 32'd0);
        clear_stats();
        run(0, IW * IH, 1'b1, 0);
        check("s4_first_x", 32'(first_x), 32'd1);
        check("s4_first_y", 32'(first_y), 32'd1);
        check("s4_pulses", 32'(pulses), 32'd6);
        check("s4_nlast", 32'(last_q.size()), 32'd1);

        // One-cycle reset mid-row 2; the discarded sample would have completed a window
        clear_stats();
        run(0, 2 * IW + 2, 1'b1, 0);
        @(negedge clk);
        rstn  = 1'b0;
        valid = 1'b1;
        sof   = 1'b0;
        px    = pix(2, 2);
        d1    = pix(1, 2);
        d2    = pix(0, 2);
        @(posedge clk);
        #1;
        check_zero("s5_rst");
        @(negedge clk);
        rstn  = 1'b1;
        valid = 1'b0;
        clear_stats();
        run(0, IW * IH, 1'b0, 0);
        check("s5_pulses", 32'(pulses), 32'd6);
        check("s5_nlast", 32'(last_q.size()), 32'd1);
        if (last_q.size() > 0) check("s5_last_idx", 32'(last_q[0]), 32'd6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
